sccb_target_regfile: RTL and testbench

- SCCB (I2C-compatible) target that emulates the OV7670 register interface.
- Sits on the sioc/siod wires in simulation and loopback builds, so the camera-init master can be checked against a real protocol responder.
- Accepts register writes into an internal 256x8 register file and serves register reads.
- Exposes a write strobe and a host read port.

---
 rtl/sccb_pkg.sv | 26 ++
 rtl/sccb_target_regfile_if.sv | 28 ++
 rtl/sccb_line_sync.sv | 45 ++++
 rtl/sccb_target_regfile.sv | 178 +++++++++++++++++
 tb/tb_sccb_target_regfile.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: FSM state encodings, OV7670 address bytes, bit/ACK slot indices.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_REG,
    ST_WDATA,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_t;

  // OV7670 7-bit target address and the two address bytes it answers to.
  localparam logic [6:0] OV7670_DEV_ADDR = 7'h21;
  localparam logic [7:0] OV7670_WR_BYTE  = 8'h42;
  localparam logic [7:0] OV7670_RD_BYTE  = 8'h43;

  // Bits per SCCB byte; the ACK occupies the 9th clock, i.e. slot index 8.
  localparam logic [3:0] SCCB_BITS     = 4'd8;
  localparam logic [3:0] SCCB_LAST_BIT = SCCB_BITS - 4'd1;
  localparam logic [3:0] SCCB_ACK_SLOT = 4'd8;

endpackage

// File: rtl/sccb_target_regfile_if.sv
// SCCB pad + register-file side-band bundle for the OV7670 target emulator.
// Latency: n/a (wires only).
// Backpressure: none; SCCB has no flow control beyond ACK/NACK.
// Ports: sioc/siod_in (pad inputs), siod_oe (open-drain pull-low), wr_strobe/wr_addr/wr_data
//        (accepted-byte notification), host_addr/host_data (independent read port), busy.
interface sccb_target_regfile_if;
  logic       sioc;
  logic       siod_in;
  logic       siod_oe;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] host_addr;
  logic [7:0] host_data;
  logic       busy;

  // Target side (the register-file emulator).
  modport slave (
    input  sioc, siod_in, host_addr,
    output siod_oe, wr_strobe, wr_addr, wr_data, host_data, busy
  );

  // Bus master / host side.
  modport master (
    output sioc, siod_in, host_addr,
    input  siod_oe, wr_strobe, wr_addr, wr_data, host_data, busy
  );
endinterface

// File: rtl/sccb_line_sync.sv
// SCCB line conditioner: 2-flop synchronizers on SCL/SDA plus edge/condition detection.
// Latency: an event acts on state at the 3rd clk edge after the pad edge.
// Backpressure: none; events are single-cycle pulses.
// Ports: clk, rst, scl_in/sda_in (async pads) -> start, stop, rise, fall (pulses), sda_s (synced SDA).
module sccb_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic start,
  output logic stop,
  output logic rise,
  output logic fall,
  output logic sda_s
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_d;
  logic       sda_d;

  // Reset to the idle-bus level (both lines high) so no phantom edge follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  // START/STOP require SCL high on both sides of the SDA edge so an SDA change
  // coinciding with an SCL edge is never mistaken for a bus condition.
  assign rise  =  scl_sync[1] & ~scl_d;
  assign fall  = ~scl_sync[1] &  scl_d;
  assign start =  scl_sync[1] &  scl_d & sda_d & ~sda_sync[1];
  assign stop  =  scl_sync[1] &  scl_d & ~sda_d & sda_sync[1];
  assign sda_s =  sda_sync[1];

endmodule

// File: rtl/sccb_target_regfile.sv
// OV7670-style SCCB target with a 256x8 register file, write strobe and host read port.
// Latency: wr_strobe 1 clk after the 8th-bit RISE is seen; host_data 1 clk after host_addr.
// Backpressure: none; the target always ACKs its own address, NACKs nothing it accepts.
// Ports: clk, rst (async, active high); bus (slave modport of sccb_target_regfile_if).
module sccb_target_regfile
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = OV7670_DEV_ADDR,
  parameter int unsigned MIN_QTR  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  sccb_target_regfile_if.slave   bus
);

  // The synchronizer plus edge detector needs a few clk cycles per SCL quarter period.
  if (MIN_QTR < 4) begin : g_qtr_chk
    $error("MIN_QTR too small for the 3-cycle line synchronizer");
  end

  localparam logic [7:0] WR_BYTE = {DEV_ADDR, 1'b0};
  localparam logic [7:0] RD_BYTE = {DEV_ADDR, 1'b1};

  logic       start, stop, rise, fall, sda_s;
  state_t     state_q, state_d;
  logic [3:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] rd_shift;
  logic [7:0] ptr;
  logic       ack_due;   // byte accepted: pull SIOD low on the next FALL
  logic       ack_on;    // inside the 9th clock; next FALL ends the ACK slot
  logic       oe_q;
  logic       wr_strobe_q;
  logic [7:0] wr_addr_q, wr_data_q, host_data_q;
  logic [7:0] regfile [256];

  logic       busy, rx_state, byte_done, do_write, hit_wr, hit_rd;
  logic [7:0] byte_val;

  sccb_line_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .scl_in (bus.sioc),
    .sda_in (bus.siod_in),
    .start  (start),
    .stop   (stop),
    .rise   (rise),
    .fall   (fall),
    .sda_s  (sda_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. START/STOP win from any state.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_ADDR;
    end else if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ADDR:      if (byte_done) state_d = hit_wr ? ST_REG : (hit_rd ? ST_RDATA : ST_IGNORE);
        ST_REG:       if (byte_done) state_d = ST_WDATA;
        ST_RDATA:     if (fall && !ack_due && !ack_on && bit_cnt == SCCB_ACK_SLOT) state_d = ST_RDATA_ACK;
        ST_RDATA_ACK: if (rise) state_d = sda_s ? ST_IGNORE : ST_RDATA;
        default:      state_d = state_q;
      endcase
    end
  end

  // Output / decode logic.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    rx_state  = (state_q == ST_ADDR) || (state_q == ST_REG) || (state_q == ST_WDATA);
    byte_val  = {shreg, sda_s};
    hit_wr    = (byte_val == WR_BYTE);
    hit_rd    = (byte_val == RD_BYTE);
    byte_done = rise && rx_state && !ack_due && !ack_on && (bit_cnt == SCCB_LAST_BIT);
    do_write  = byte_done && (state_q == ST_WDATA);
  end

  // Bit engine: receive shift, ACK slot, read-data serializer, register pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      rd_shift    <= '0;
      ptr         <= '0;
      ack_due     <= 1'b0;
      ack_on      <= 1'b0;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_strobe_q <= do_write;
      if (do_write) begin
        wr_addr_q <= ptr;
        wr_data_q <= byte_val;
      end
      if (start || stop) begin
        bit_cnt <= '0;
        ack_due <= 1'b0;
        ack_on  <= 1'b0;
        oe_q    <= 1'b0;
      end else if (rise) begin
        if (state_q == ST_RDATA_ACK) begin
          // Master ACK: prefetch the next register; ack_on makes the coming FALL
          // present its MSB exactly like the end of an address ACK.
          if (!sda_s) begin
            ptr      <= ptr + 8'd1;
            rd_shift <= regfile[ptr + 8'd1];
            ack_on   <= 1'b1;
          end
        end else if (rx_state && !ack_due && !ack_on) begin
          shreg <= byte_val[6:0];
          if (byte_done) begin
            bit_cnt <= '0;
            ack_due <= (state_q != ST_ADDR) || hit_wr || hit_rd;
            if (state_q == ST_ADDR && hit_rd) rd_shift <= regfile[ptr];
            if (state_q == ST_REG)            ptr      <= byte_val;
            if (do_write)                     ptr      <= ptr + 8'd1;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
      end else if (fall) begin
        if (ack_due) begin
          oe_q    <= 1'b1;
          ack_due <= 1'b0;
          ack_on  <= 1'b1;
        end else if (ack_on) begin
          ack_on <= 1'b0;
          if (state_q == ST_RDATA) begin
            oe_q     <= ~rd_shift[7];
            rd_shift <= {rd_shift[6:0], 1'b0};
            bit_cnt  <= 4'd1;
          end else begin
            oe_q    <= 1'b0;
            bit_cnt <= '0;
          end
        end else if (state_q == ST_RDATA) begin
          if (bit_cnt == SCCB_ACK_SLOT) begin
            oe_q <= 1'b0;                   // release for the master's ACK/NACK
          end else begin
            oe_q     <= ~rd_shift[7];
            rd_shift <= {rd_shift[6:0], 1'b0};
            bit_cnt  <= bit_cnt + 4'd1;
          end
        end
      end
    end
  end

  // Register file; the host read samples the pre-write contents on a same-cycle hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regfile     <= '{default: 8'h00};
      host_data_q <= '0;
    end else begin
      if (do_write) regfile[ptr] <= byte_val;
      host_data_q <= regfile[bus.host_addr];
    end
  end

  assign bus.siod_oe   = oe_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.host_data = host_data_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_sccb_target_regfile.sv
// Directed bench for sccb_target_regfile: a bit-banged SCCB master on an open-drain SIOD.
// Latency: SCL quarter period of Q clk cycles.
// Backpressure: n/a.
module tb_sccb_target_regfile;
  import sccb_pkg::*;

  localparam int Q = 20;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  int total     = 0;
  int bad       = 0;
  int oe_cycles = 0;
  int n_strb    = 0;
  logic [7:0] sa [16];
  logic [7:0] sd [16];
  logic [7:0] sh [16];

  sccb_target_regfile_if bif ();

  assign bif.sioc    = m_scl;
  assign bif.siod_in = m_sda & ~bif.siod_oe;

  sccb_target_regfile #(.DEV_ADDR(OV7670_DEV_ADDR), .MIN_QTR(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  // Record every strobe cycle and every cycle SIOD is pulled low by the target.
  always @(negedge clk) begin
    if (bif.siod_oe) oe_cycles++;
    if (bif.wr_strobe) begin
      if (n_strb < 16) begin
        sa[n_strb] = bif.wr_addr;
        sd[n_strb] = bif.wr_data;
        sh[n_strb] = bif.host_data;
      end
      n_strb++;
    end
  end

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  // Works from idle (SCL high) and as a repeated START (SCL low).
  task automatic bus_start();
    m_sda = 1'b1; qwait();
    m_scl = 1'b1; qwait();
    m_sda = 1'b0; qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; qwait();
    m_scl = 1'b1; qwait();
    m_sda = 1'b1; qwait();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      m_sda = b[7-i]; qwait();
      m_scl = 1'b1;   qwait(); qwait();
      m_scl = 1'b0;   qwait();
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    m_sda = 1'b1; qwait();
    m_scl = 1'b1; qwait();
    ack = bif.siod_in;
    qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      m_sda = 1'b1; qwait();
      m_scl = 1'b1; qwait();
      d[7-i] = bif.siod_in;
      qwait();
      m_scl = 1'b0; qwait();
    end
    m_sda = mack; qwait();
    m_scl = 1'b1; qwait(); qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic host_rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bif.host_addr = a;
    @(posedge clk);
    #1;
    d = bif.host_data;
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         oe_base;

    bif.host_addr = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_bit ("rst_siod_oe",   bif.siod_oe,   1'b0);
    chk_bit ("rst_wr_strobe", bif.wr_strobe, 1'b0);
    chk_byte("rst_wr_addr",   bif.wr_addr,   8'h00);
    chk_byte("rst_wr_data",   bif.wr_data,   8'h00);
    chk_byte("rst_host_data", bif.host_data, 8'h00);
    chk_bit ("rst_busy",      bif.busy,      1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Single register write 0x12 <- 0x80.
    bus_start();
    chk_bit("a_busy_start", bif.busy, 1'b1);
    write_byte(OV7670_WR_BYTE, a); chk_bit("a_ack_addr", a, 1'b0);
    write_byte(8'h12, a);          chk_bit("a_ack_reg",  a, 1'b0);
    write_byte(8'h80, a);          chk_bit("a_ack_data", a, 1'b0);
    bus_stop();
    chk_bit ("a_busy_stop", bif.busy, 1'b0);
    chk_int ("a_n_strobe",  n_strb, 1);
    chk_byte("a_wr_addr",   sa[0], 8'h12);
    chk_byte("a_wr_data",   sd[0], 8'h80);
    host_rd(8'h12, d);
    chk_byte("a_host_12", d, 8'h80);

    // Foreign address: ignored entirely.
    oe_base = oe_cycles;
    bus_start();
    write_byte(8'h40, a); chk_bit("b_nack_addr", a, 1'b1);
    write_byte(8'h12, a);
    write_byte(8'h55, a); chk_bit("b_nack_data", a, 1'b1);
    bus_stop();
    chk_int ("b_oe_cycles", oe_cycles - oe_base, 0);
    chk_int ("b_n_strobe",  n_strb, 1);
    host_rd(8'h12, d);
    chk_byte("b_host_12", d, 8'h80);

    // Pointer wrap; host_addr parked on 0xFF to see read-before-write.
    host_rd(8'hFF, d);
    chk_byte("c_host_ff_pre", d, 8'h00);
    bus_start();
    write_byte(OV7670_WR_BYTE, a);
    write_byte(8'hFF, a);
    write_byte(8'hAA, a); chk_bit("c_ack_aa", a, 1'b0);
    write_byte(8'hBB, a); chk_bit("c_ack_bb", a, 1'b0);
    bus_stop();
    chk_int ("c_n_strobe", n_strb, 3);
    chk_byte("c_addr1", sa[1], 8'hFF);
    chk_byte("c_data1", sd[1], 8'hAA);
    chk_byte("c_rbw1",  sh[1], 8'h00);
    chk_byte("c_addr2", sa[2], 8'h00);
    chk_byte("c_data2", sd[2], 8'hBB);
    chk_byte("c_rbw2",  sh[2], 8'hAA);
    host_rd(8'hFF, d); chk_byte("c_host_ff", d, 8'hAA);
    host_rd(8'h00, d); chk_byte("c_host_00", d, 8'hBB);

    // Preload 0x40..0x42, set the pointer, read one byte with NACK.
    bus_start();
    write_byte(OV7670_WR_BYTE, a);
    write_byte(8'h40, a);
    write_byte(8'hC3, a);
    write_byte(8'h81, a);
    write_byte(8'h9C, a);
    bus_stop();
    chk_int("d_n_strobe_pre", n_strb, 6);
    bus_start();
    write_byte(OV7670_WR_BYTE, a);
    write_byte(8'h40, a);
    bus_stop();
    chk_int("d_n_strobe_ptr", n_strb, 6);
    bus_start();
    write_byte(OV7670_RD_BYTE, a); chk_bit("d_ack_rd", a, 1'b0);
    read_byte(1'b1, d);            chk_byte("d_rd_40", d, 8'hC3);
    bus_stop();
    chk_bit("d_busy", bif.busy, 1'b0);
    chk_bit("d_oe",   bif.siod_oe, 1'b0);

    // Sequential read with master ACKs, then a repeated START mid-read.
    bus_start();
    write_byte(OV7670_WR_BYTE, a);
    write_byte(8'h40, a);
    bus_stop();
    bus_start();
    write_byte(OV7670_RD_BYTE, a);
    read_byte(1'b0, d); chk_byte("e_rd_40", d, 8'hC3);
    read_byte(1'b0, d); chk_byte("e_rd_41", d, 8'h81);
    bus_start();
    chk_bit("e_oe_rstart",   bif.siod_oe, 1'b0);
    chk_bit("e_busy_rstart", bif.busy,    1'b1);
    write_byte(OV7670_WR_BYTE, a); chk_bit("e_ack_after_rstart", a, 1'b0);
    write_byte(8'h05, a);
    write_byte(8'h77, a);
    bus_stop();
    chk_int ("e_n_strobe", n_strb, 7);
    chk_byte("e_addr6", sa[6], 8'h05);
    chk_byte("e_data6", sd[6], 8'h77);

    // STOP after 5 data bits: partial byte discarded.
    bus_start();
    write_byte(OV7670_WR_BYTE, a);
    write_byte(8'h20, a);
    send_bits(8'hE8, 5);
    bus_stop();
    chk_int ("f_n_strobe", n_strb, 7);
    chk_bit ("f_busy",     bif.busy, 1'b0);
    host_rd(8'h20, d);
    chk_byte("f_host_20", d, 8'h00);

    // Reset asserted while the target is driving its ACK.
    bus_start();
    send_bits(OV7670_WR_BYTE, 8);
    chk_bit("g_oe_before_rst", bif.siod_oe, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk_bit("g_oe_async_clr", bif.siod_oe, 1'b0);
    chk_bit("g_busy_rst",     bif.busy,    1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus_stop();
    chk_bit("g_busy_after", bif.busy, 1'b0);
    chk_int("g_n_strobe",   n_strb, 7);
    host_rd(8'h12, d);
    chk_byte("g_host_12_cleared", d, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
